// File: rtl/dmem_arbiter.sv
// Shares the data memory between the core load/store port and the debug/loader port.
// Core has priority, bounded by a starvation counter; debug can lock the memory for bursts.
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [2:0]  c_f3,
   output logic        c_gnt,
   output logic        c_stall,
   output logic        c_rvalid,
   output logic [31:0] c_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_f3,
   input  logic        d_lock,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_f3,
   output logic        mem_wren,
   output logic        mem_rden,
   output logic        mem_cs,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, CORE, DBG, LOCKED} state_t;

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;

   // Grant decision: combinational from requests and registered state.
   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (state == LOCKED) begin
            d_gnt = d_req;
         end else begin
            c_gnt = c_req & ~(d_req & (starve_cnt == LIMIT));
            d_gnt = d_req & ~c_gnt;
         end
      end
   end

   assign c_stall = c_req & ~c_gnt;
   assign busy    = (state == LOCKED);

   // Memory mux: idle values when nobody is granted.
   always_comb begin
      mem_cs    = 1'b1;
      mem_wren  = 1'b0;
      mem_rden  = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_f3    = 3'h0;
      if (c_gnt) begin
         mem_cs    = 1'b0;
         mem_wren  = c_we;
         mem_rden  = ~c_we;
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
         mem_f3    = c_f3;
      end else if (d_gnt) begin
         mem_cs    = 1'b0;
         mem_wren  = d_we;
         mem_rden  = ~d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_f3    = d_f3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         c_rvalid   <= 1'b0;
         d_rvalid   <= 1'b0;
         c_rdata    <= 32'h0;
         d_rdata    <= 32'h0;
      end else begin
         // Owner of the last accepted beat; LOCKED only releases on an unlocked debug beat.
         if (state == LOCKED) begin
            if (d_gnt && !d_lock) state <= DBG;
         end else if (c_gnt) begin
            state <= CORE;
         end else if (d_gnt) begin
            state <= d_lock ? LOCKED : DBG;
         end else begin
            state <= IDLE;
         end

         if (state != LOCKED) begin
            if (d_gnt || !d_req)
               starve_cnt <= '0;
            else if (c_gnt && starve_cnt != LIMIT)
               starve_cnt <= starve_cnt + CNT_W'(1);
         end

         c_rvalid <= c_gnt & ~c_we;
         d_rvalid <= d_gnt & ~d_we;
         if (c_gnt && !c_we) c_rdata <= mem_rdata;
         if (d_gnt && !d_we) d_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, reads, writes, starvation, locked bursts, reset mid-lock.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, d_req, d_we, d_lock;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
   logic [2:0]  c_f3, d_f3;
   logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
   logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata;
   logic [2:0]  mem_f3;
   logic        mem_wren, mem_rden, mem_cs, busy;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_f3(c_f3),
      .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_f3(d_f3),
      .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_f3(mem_f3),
      .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_cs(mem_cs),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; c_req = 1'b1; d_req = 1'b1;
      c_we = 1'b0; d_we = 1'b0; d_lock = 1'b0;
      c_addr = 32'h0; c_wdata = 32'h0; c_f3 = 3'h0;
      d_addr = 32'h0; d_wdata = 32'h0; d_f3 = 3'h0;
      mem_rdata = 32'h5555_AAAA;
      #2;
      chk("rst_c_gnt", 32'(c_gnt), 32'd0);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_cs", 32'(mem_cs), 32'd1);
      tick(); tick();
      chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_c_rdata", c_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Core read
      reset = 1'b0; d_req = 1'b0;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h8; c_f3 = 3'h2; mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rd_c_gnt", 32'(c_gnt), 32'd1);
      chk("rd_rden", 32'(mem_rden), 32'd1);
      chk("rd_cs", 32'(mem_cs), 32'd0);
      chk("rd_addr", mem_addr, 32'h8);
      chk("rd_f3", 32'(mem_f3), 32'd2);
      chk("rd_stall", 32'(c_stall), 32'd0);
      tick();
      c_req = 1'b0; mem_rdata = 32'h0;
      chk("rd_rvalid1", 32'(c_rvalid), 32'd1);
      chk("rd_rdata", c_rdata, 32'hDEAD_BEEF);
      chk("rd_d_rvalid", 32'(d_rvalid), 32'd0);
      tick();
      chk("rd_rvalid2", 32'(c_rvalid), 32'd0);
      chk("rd_rdata_hold", c_rdata, 32'hDEAD_BEEF);

      // Debug write
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678; d_f3 = 3'h1;
      #1;
      chk("dw_gnt", 32'(d_gnt), 32'd1);
      chk("dw_wren", 32'(mem_wren), 32'd1);
      chk("dw_rden", 32'(mem_rden), 32'd0);
      chk("dw_wdata", mem_wdata, 32'h1234_5678);
      chk("dw_addr", mem_addr, 32'h40);
      tick();
      chk("dw_rvalid", 32'(d_rvalid), 32'd0);
      chk("dw_busy", 32'(busy), 32'd0);

      // Starvation: 4 core grants, then debug, then core again
      c_req = 1'b1; c_we = 1'b1; c_wdata = 32'hC0DE;
      for (int i = 1; i <= 6; i++) begin
         #1;
         chk($sformatf("st_c_gnt%0d", i), 32'(c_gnt), (i == 5) ? 32'd0 : 32'd1);
         chk($sformatf("st_d_gnt%0d", i), 32'(d_gnt), (i == 5) ? 32'd1 : 32'd0);
         chk($sformatf("st_stall%0d", i), 32'(c_stall), (i == 5) ? 32'd1 : 32'd0);
         tick();
      end
      d_req = 1'b0;
      tick();

      // Lock burst: counter reaches limit, then 4 debug read beats
      d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk($sformatf("lk_pre_c_gnt%0d", i), 32'(c_gnt), 32'd1);
         tick();
      end
      for (int i = 1; i <= 4; i++) begin
         d_lock = (i < 4);
         mem_rdata = 32'hA000_0000 + 32'(i);
         #1;
         chk($sformatf("lk_d_gnt%0d", i), 32'(d_gnt), 32'd1);
         chk($sformatf("lk_c_gnt%0d", i), 32'(c_gnt), 32'd0);
         chk($sformatf("lk_busy%0d", i), 32'(busy), (i == 1) ? 32'd0 : 32'd1);
         tick();
      end
      #1;
      chk("lk_rel_busy", 32'(busy), 32'd0);
      chk("lk_rel_c_gnt", 32'(c_gnt), 32'd1);
      chk("lk_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("lk_d_rdata", d_rdata, 32'hA000_0004);
      tick();

      // Lock with gap: core stays blocked while debug idles
      c_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_lock = 1'b1;
      tick();
      chk("gap_busy0", 32'(busy), 32'd1);
      c_req = 1'b1; d_req = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         #1;
         chk($sformatf("gap_c_gnt%0d", i), 32'(c_gnt), 32'd0);
         chk($sformatf("gap_cs%0d", i), 32'(mem_cs), 32'd1);
         chk($sformatf("gap_stall%0d", i), 32'(c_stall), 32'd1);
         tick();
         chk($sformatf("gap_busy%0d", i), 32'(busy), 32'd1);
      end

      // Reset mid-lock with a read in flight
      d_req = 1'b1; d_we = 1'b0; mem_rdata = 32'h7777_0001;
      #1;
      chk("rml_d_gnt", 32'(d_gnt), 32'd1);
      tick();
      chk("rml_d_rvalid", 32'(d_rvalid), 32'd1);
      reset = 1'b1; d_req = 1'b0; c_req = 1'b1;
      #1;
      chk("rml_c_gnt_rst", 32'(c_gnt), 32'd0);
      chk("rml_cs_rst", 32'(mem_cs), 32'd1);
      tick();
      chk("rml_busy", 32'(busy), 32'd0);
      chk("rml_d_rvalid0", 32'(d_rvalid), 32'd0);
      chk("rml_d_rdata", d_rdata, 32'h0);
      chk("rml_cnt", 32'(dut.starve_cnt), 32'd0);
      reset = 1'b0; d_req = 1'b1;
      #1;
      chk("rml_c_gnt", 32'(c_gnt), 32'd1);
      chk("rml_d_gnt0", 32'(d_gnt), 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
